id_ex_operand_stage: RTL
========================

# id_ex_operand_stage

ID/EX pipeline stage that sits directly upstream of the ALU and drives its `Src_1`, `Src_2`, `Shamt` and `Funct` inputs. It registers decoded operands and control from the decode stage, and resolves RAW hazards combinationally by forwarding from EX/MEM and MEM/WB. It detects load-use hazards, inserting a bubble and stalling decode for one cycle, and supports external stall and flush.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `RW`, 5, register-index width

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `id_valid`  in  1  decode stage holds a real instruction
- `id_rs_data`, `id_rt_data`  in  XLEN  register-file read data
- `id_rs`, `id_rt`, `id_rd`  in  RW  source/destination indices
- `id_shamt`  in  5  shift amount
- `id_funct`  in  2  ALU op: 00 add, 01 sub, 10 sll, 11 or
- `id_reg_write`, `id_mem_read`  in  1  control for later stages
- `stall_in`  in  1  downstream freeze: hold stage contents
- `flush`  in  1  squash: load bubble
- `exm_reg_write`  in  1  EX/MEM will write `exm_rd`
- `exm_rd`  in  RW  EX/MEM destination
- `exm_result`  in  XLEN  EX/MEM ALU result
- `wb_reg_write`  in  1  MEM/WB will write `wb_rd`
- `wb_rd`  in  RW  MEM/WB destination
- `wb_data`  in  XLEN  MEM/WB write-back data
- `Src_1`, `Src_2`  out  XLEN  forwarded ALU operands
- `Shamt`  out  5  to ALU
- `Funct`  out  2  to ALU
- `ex_valid`, `ex_reg_write`, `ex_mem_read`  out  1  registered control
- `ex_rd`  out  RW  registered destination
- `stall_out`  out  1  freeze PC and IF/ID

## Operation
- Internal state: `valid`, `rs`, `rt`, `rd`, `rs_data`, `rt_data`, `shamt`, `funct`, `reg_write`, `mem_read`.
- A bubble is all state zero: `valid` = 0, control 0, indices 0, data 0, `funct` = 00.
- Load-use hazard: `ex_valid & ex_mem_read & ex_rd != 0 & id_valid & (id_rs == ex_rd | id_rt == ex_rd)`.
- `stall_out` = load-use hazard OR `stall_in`, combinational.
- Next-state priority, highest first:
  1. `flush`: load bubble.
  2. `stall_in`: hold all state.
  3. load-use hazard: load bubble.
  4. Otherwise: load from `id_*`, with `valid` = `id_valid`.
- Forwarding for `Src_1` (register `rs`); `Src_2` identical using `rt`. Combinational, evaluated on registered indices:
  - `exm_reg_write & exm_rd != 0 & exm_rd == rs` → `exm_result`.
  - Else `wb_reg_write & wb_rd != 0 & wb_rd == rs` → `wb_data`.
  - Else registered `rs_data`.
- Register 0 is never forwarded.
- EX/MEM beats MEM/WB when both match.
- `Shamt`, `Funct`, `ex_*` are direct state outputs.
- With `valid` = 0, outputs still follow the rules above. Consumers gate on `ex_valid`.
- No arithmetic in this block. All widths pass through unchanged.

## Timing
- `rst` asserted (asynchronous): state becomes a bubble immediately. All outputs 0 and `stall_out` 0, except `Src_*` may forward if `exm`/`wb` inputs match `rs`/`rt` = 0. That cannot occur, because register 0 is excluded.
- Latency: `id_*` appears on outputs one `clk` edge later.
- A load-use hazard costs exactly one bubble cycle. On the next edge the stage holds no load, so `stall_out` drops and the held ID instruction enters. Its operand is then forwarded from EX/MEM or MEM/WB.
- Flush during a hazard: bubble loaded; `stall_out` may still be high that cycle (harmless).
- Reset mid-stall: stage returns to bubble; `stall_out` follows `stall_in` only.

## Structure
- Package `cpu_pkg`:
  - `XLEN`, `RW`.
  - `alu_funct_t` with `FN_ADD` = 00, `FN_SUB` = 01, `FN_SLL` = 10, `FN_OR` = 11.
  - Bubble constant.
- Sub-module `fwd_mux`: one index plus EX/MEM and MEM/WB ports, yields an operand. Instantiated twice.

## Test plan
- Reset mid-operation: assert `rst` asynchronously between edges → all outputs 0 before next edge, `ex_valid` = 0.
- Plain issue: `id_rs_data` = 5, `id_rt_data` = 3, `id_funct` = 01, no matches → next cycle `Src_1` = 5, `Src_2` = 3, `Funct` = 01, `ex_valid` = 1.
- Forward priority: `rs` = 4, `exm_rd` = 4 with `exm_result` = 0xAA, `wb_rd` = 4 with `wb_data` = 0xBB → `Src_1` = 0xAA.
  - Drop `exm_reg_write` → `Src_1` = 0xBB.
  - `rs` = 0 with both matching → `Src_1` = `rs_data`.
- Load-use: EX holds a load to `rd` = 7, ID reads `rt` = 7 → `stall_out` = 1 for one cycle, then a bubble.
  - Following cycle: ID instruction enters with `Src_2` from MEM/WB forwarding.
- Stall/flush priority: `stall_in` = 1 for 3 cycles → state held constant.
  - `stall_in` and `flush` together → bubble loaded.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, ALU opcode encoding and the ID/EX state record for the
// operand stage that feeds the ALU.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int SHW  = 5;

  typedef enum logic [1:0] {
    FN_ADD = 2'b00,
    FN_SUB = 2'b01,
    FN_SLL = 2'b10,
    FN_OR  = 2'b11
  } alu_funct_t;

  typedef struct packed {
    logic             valid;
    logic [RW-1:0]    rs;
    logic [RW-1:0]    rt;
    logic [RW-1:0]    rd;
    logic [XLEN-1:0]  rs_data;
    logic [XLEN-1:0]  rt_data;
    logic [SHW-1:0]   shamt;
    alu_funct_t       funct;
    logic             reg_write;
    logic             mem_read;
  } id_ex_state_t;

  // A bubble is the all-zero record: invalid, no control, r0 indices, ADD.
  localparam id_ex_state_t BUBBLE = id_ex_state_t'('0);

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Signal bundle between decode, the later pipeline stages and the ID/EX
// operand stage; master drives decode/forwarding inputs, slave is the stage.
interface id_ex_operand_stage_if;
  import cpu_pkg::*;

  logic             id_valid;
  logic [XLEN-1:0]  id_rs_data;
  logic [XLEN-1:0]  id_rt_data;
  logic [RW-1:0]    id_rs;
  logic [RW-1:0]    id_rt;
  logic [RW-1:0]    id_rd;
  logic [SHW-1:0]   id_shamt;
  logic [1:0]       id_funct;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             stall_in;
  logic             flush;
  logic             exm_reg_write;
  logic [RW-1:0]    exm_rd;
  logic [XLEN-1:0]  exm_result;
  logic             wb_reg_write;
  logic [RW-1:0]    wb_rd;
  logic [XLEN-1:0]  wb_data;

  logic [XLEN-1:0]  Src_1;
  logic [XLEN-1:0]  Src_2;
  logic [SHW-1:0]   Shamt;
  logic [1:0]       Funct;
  logic             ex_valid;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [RW-1:0]    ex_rd;
  logic             stall_out;

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_rs, id_rt, id_rd,
           id_shamt, id_funct, id_reg_write, id_mem_read,
           stall_in, flush,
           exm_reg_write, exm_rd, exm_result,
           wb_reg_write, wb_rd, wb_data,
    output Src_1, Src_2, Shamt, Funct,
           ex_valid, ex_reg_write, ex_mem_read, ex_rd, stall_out
  );

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_rs, id_rt, id_rd,
           id_shamt, id_funct, id_reg_write, id_mem_read,
           stall_in, flush,
           exm_reg_write, exm_rd, exm_result,
           wb_reg_write, wb_rd, wb_data,
    input  Src_1, Src_2, Shamt, Funct,
           ex_valid, ex_reg_write, ex_mem_read, ex_rd, stall_out
  );

endinterface

// File: rtl/fwd_mux.sv
// Operand bypass for one source register: EX/MEM result wins over MEM/WB
// data, which wins over the value read from the register file in decode.
module fwd_mux #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic [RW-1:0]    i_idx,
  input  logic [XLEN-1:0]  i_reg_data,
  input  logic             i_exm_reg_write,
  input  logic [RW-1:0]    i_exm_rd,
  input  logic [XLEN-1:0]  i_exm_result,
  input  logic             i_wb_reg_write,
  input  logic [RW-1:0]    i_wb_rd,
  input  logic [XLEN-1:0]  i_wb_data,
  output logic [XLEN-1:0]  o_operand
);

  logic w_exm_hit;
  logic w_wb_hit;

  // r0 is hard-wired zero, so a write targeting it must never be bypassed.
  assign w_exm_hit = i_exm_reg_write && (i_exm_rd != '0) && (i_exm_rd == i_idx);
  assign w_wb_hit  = i_wb_reg_write  && (i_wb_rd  != '0) && (i_wb_rd  == i_idx);

  always_comb begin
    o_operand = i_reg_data;
    if (w_exm_hit) begin
      o_operand = i_exm_result;
    end else if (w_wb_hit) begin
      o_operand = i_wb_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register in front of the ALU: captures decoded operands,
// bypasses from EX/MEM and MEM/WB, and inserts a bubble on load-use hazards.
module id_ex_operand_stage
  import cpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  id_ex_operand_stage_if.slave    bus
);

  id_ex_state_t     r_state;
  id_ex_state_t     w_state_next;
  id_ex_state_t     w_id_state;
  logic             w_load_use;

  logic [RW-1:0]    w_idx      [2];
  logic [XLEN-1:0]  w_reg_data [2];
  logic [XLEN-1:0]  w_operand  [2];

  // A load sitting in EX cannot supply its data until MEM, so a dependent
  // instruction in decode has to wait one cycle behind a bubble.
  assign w_load_use = r_state.valid && r_state.mem_read && (r_state.rd != '0) &&
                      bus.id_valid &&
                      ((bus.id_rs == r_state.rd) || (bus.id_rt == r_state.rd));

  always_comb begin
    w_id_state           = BUBBLE;
    w_id_state.valid     = bus.id_valid;
    w_id_state.rs        = bus.id_rs;
    w_id_state.rt        = bus.id_rt;
    w_id_state.rd        = bus.id_rd;
    w_id_state.rs_data   = bus.id_rs_data;
    w_id_state.rt_data   = bus.id_rt_data;
    w_id_state.shamt     = bus.id_shamt;
    w_id_state.funct     = alu_funct_t'(bus.id_funct);
    w_id_state.reg_write = bus.id_reg_write;
    w_id_state.mem_read  = bus.id_mem_read;
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.flush) begin
      w_state_next = BUBBLE;
    end else if (bus.stall_in) begin
      w_state_next = r_state;
    end else if (w_load_use) begin
      w_state_next = BUBBLE;
    end else begin
      w_state_next = w_id_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BUBBLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign w_idx[0]      = r_state.rs;
  assign w_idx[1]      = r_state.rt;
  assign w_reg_data[0] = r_state.rs_data;
  assign w_reg_data[1] = r_state.rt_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_mux #(
        .XLEN (XLEN),
        .RW   (RW)
      ) u_fwd_mux (
        .i_idx           (w_idx[gi]),
        .i_reg_data      (w_reg_data[gi]),
        .i_exm_reg_write (bus.exm_reg_write),
        .i_exm_rd        (bus.exm_rd),
        .i_exm_result    (bus.exm_result),
        .i_wb_reg_write  (bus.wb_reg_write),
        .i_wb_rd         (bus.wb_rd),
        .i_wb_data       (bus.wb_data),
        .o_operand       (w_operand[gi])
      );
    end
  endgenerate

  assign bus.Src_1        = w_operand[0];
  assign bus.Src_2        = w_operand[1];
  assign bus.Shamt        = r_state.shamt;
  assign bus.Funct        = r_state.funct;
  assign bus.ex_valid     = r_state.valid;
  assign bus.ex_reg_write = r_state.reg_write;
  assign bus.ex_mem_read  = r_state.mem_read;
  assign bus.ex_rd        = r_state.rd;
  assign bus.stall_out    = w_load_use || bus.stall_in;

endmodule
